// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer for a shared word memory: grants fetch or data
// accesses, holds the memory port MEM_LATENCY cycles, then pulses the matching Ready.
module mem_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IfReq,
  input  logic [31:0] IfAddr,
  output logic [31:0] IfData,
  output logic        IfReady,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWriteData,
  output logic [31:0] DReadData,
  output logic        DReady,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemReadData,
  output logic        Busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       last_gnt;
  logic       pick_d;
  logic       pick_store;

  // On contention the requester that did not win last time gets the port.
  always_comb begin
    pick_d     = DReq && (!IfReq || !last_gnt);
    pick_store = pick_d && DWrite;
  end

  assign Busy = (state != IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      last_gnt     <= 1'b0;
      MemAddr      <= 32'd0;
      MemWriteData <= 32'd0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      IfData       <= 32'd0;
      DReadData    <= 32'd0;
      IfReady      <= 1'b0;
      DReady       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IfReq || DReq) begin
            MemAddr  <= pick_d ? DAddr : IfAddr;
            if (pick_store) MemWriteData <= DWriteData;
            MemRead  <= !pick_store;
            MemWrite <= pick_store;
            last_gnt <= pick_d;
            cnt      <= CNT_INIT;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // A store completes without touching the read-data register.
            if (!MemWrite) begin
              if (last_gnt) DReadData <= MemReadData;
              else          IfData    <= MemReadData;
            end
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            if (last_gnt) DReady  <= 1'b1;
            else          IfReady <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          IfReady <= 1'b0;
          DReady  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LATENCY=2 and one at
// MEM_LATENCY=1, each behind its own small memory model.
module tb_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ifReq, dReq, dWrite;
  logic [31:0] ifAddr, dAddr, dWriteData;
  logic [31:0] ifData, dReadData, memAddr, memWriteData, memReadData;
  logic        ifReady, dReady, memRead, memWrite, busy;

  logic        fReq;
  logic [31:0] fAddr;
  logic        fDReq, fDWrite;
  logic [31:0] fDAddr, fDWriteData;
  logic [31:0] fIfData, fDReadData, fMemAddr, fMemWriteData, fMemReadData;
  logic        fIfReady, fDReady, fMemRead, fMemWrite, fBusy;

  logic [31:0] mem  [0:63];
  logic [31:0] mem1 [0:63];

  int testCount = 0;
  int failCount = 0;

  always #5 Clk = ~Clk;

  mem_arbiter #(.MEM_LATENCY(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .IfReq(ifReq), .IfAddr(ifAddr), .IfData(ifData), .IfReady(ifReady),
    .DReq(dReq), .DWrite(dWrite), .DAddr(dAddr), .DWriteData(dWriteData),
    .DReadData(dReadData), .DReady(dReady),
    .MemAddr(memAddr), .MemWriteData(memWriteData), .MemRead(memRead),
    .MemWrite(memWrite), .MemReadData(memReadData), .Busy(busy)
  );

  mem_arbiter #(.MEM_LATENCY(1)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .IfReq(fReq), .IfAddr(fAddr), .IfData(fIfData), .IfReady(fIfReady),
    .DReq(fDReq), .DWrite(fDWrite), .DAddr(fDAddr), .DWriteData(fDWriteData),
    .DReadData(fDReadData), .DReady(fDReady),
    .MemAddr(fMemAddr), .MemWriteData(fMemWriteData), .MemRead(fMemRead),
    .MemWrite(fMemWrite), .MemReadData(fMemReadData), .Busy(fBusy)
  );

  // Word-addressed memories: combinational read, write on each edge MemWrite is high.
  assign memReadData  = mem[memAddr[7:2]];
  assign fMemReadData = mem1[fMemAddr[7:2]];

  always @(posedge Clk) begin
    if (memWrite) mem[memAddr[7:2]] <= memWriteData;
    if (fMemWrite) mem1[fMemAddr[7:2]] <= fMemWriteData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge Clk);
  endtask

  initial begin
    logic seenReady;
    for (int i = 0; i < 64; i++) begin
      mem[i]  = 32'h0;
      mem1[i] = 32'h0;
    end
    mem[3]  = 32'h8C220004;
    mem[4]  = 32'h12345678;
    mem[8]  = 32'hAAAA5555;
    mem1[3] = 32'hCAFEF00D;

    Reset = 1'b1;
    ifReq = 0; dReq = 0; dWrite = 0; ifAddr = 0; dAddr = 0; dWriteData = 0;
    fReq = 0; fAddr = 0; fDReq = 0; fDWrite = 0; fDAddr = 0; fDWriteData = 0;

    applyStimulus(2);
    checkOutput("reset_memread", {31'd0, memRead}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_memaddr", memAddr, 32'd0);
    checkOutput("reset_ifdata", ifData, 32'd0);
    checkOutput("reset_dreaddata", dReadData, 32'd0);
    checkOutput("reset_ready", {30'd0, ifReady, dReady}, 32'd0);

    // Fetch of word 3.
    Reset = 1'b0;
    applyStimulus(1);
    ifReq = 1; ifAddr = 32'h0C;
    applyStimulus(1);
    checkOutput("fetch_e0_memread", {31'd0, memRead}, 32'd1);
    checkOutput("fetch_e0_memaddr", memAddr, 32'h0C);
    checkOutput("fetch_e0_memwrite", {31'd0, memWrite}, 32'd0);
    checkOutput("fetch_e0_busy", {31'd0, busy}, 32'd1);
    applyStimulus(1);
    checkOutput("fetch_e1_memread", {31'd0, memRead}, 32'd1);
    checkOutput("fetch_e1_ifready", {31'd0, ifReady}, 32'd0);
    applyStimulus(1);
    checkOutput("fetch_e2_ifready", {31'd0, ifReady}, 32'd1);
    checkOutput("fetch_e2_ifdata", ifData, 32'h8C220004);
    checkOutput("fetch_e2_memread", {31'd0, memRead}, 32'd0);
    ifReq = 0;
    applyStimulus(1);
    checkOutput("fetch_e3_ifready", {31'd0, ifReady}, 32'd0);
    checkOutput("fetch_e3_busy", {31'd0, busy}, 32'd0);

    // Store to 0x40, then a load from the same address.
    dReq = 1; dWrite = 1; dAddr = 32'h40; dWriteData = 32'hDEADBEEF;
    applyStimulus(1);
    checkOutput("store_e0_memwrite", {31'd0, memWrite}, 32'd1);
    checkOutput("store_e0_memread", {31'd0, memRead}, 32'd0);
    checkOutput("store_e0_wdata", memWriteData, 32'hDEADBEEF);
    applyStimulus(1);
    checkOutput("store_e1_memwrite", {31'd0, memWrite}, 32'd1);
    applyStimulus(1);
    checkOutput("store_e2_dready", {31'd0, dReady}, 32'd1);
    checkOutput("store_e2_dreaddata", dReadData, 32'd0);
    checkOutput("store_e2_memwrite", {31'd0, memWrite}, 32'd0);
    dWrite = 0;
    applyStimulus(1);
    checkOutput("store_e3_dready", {31'd0, dReady}, 32'd0);
    checkOutput("store_e3_busy", {31'd0, busy}, 32'd0);
    applyStimulus(1);
    checkOutput("load_e0_memread", {31'd0, memRead}, 32'd1);
    checkOutput("load_e0_memaddr", memAddr, 32'h40);
    applyStimulus(2);
    checkOutput("load_e2_dready", {31'd0, dReady}, 32'd1);
    checkOutput("load_e2_dreaddata", dReadData, 32'hDEADBEEF);
    dReq = 0;
    applyStimulus(1);

    // Address change while the fetch is in flight.
    ifReq = 1; ifAddr = 32'h10;
    applyStimulus(1);
    checkOutput("addrchg_e0_memaddr", memAddr, 32'h10);
    ifAddr = 32'h20;
    applyStimulus(1);
    checkOutput("addrchg_e1_memaddr", memAddr, 32'h10);
    applyStimulus(1);
    checkOutput("addrchg_e2_ifready", {31'd0, ifReady}, 32'd1);
    checkOutput("addrchg_e2_ifdata", ifData, 32'h12345678);
    ifReq = 0;
    applyStimulus(1);

    // Contention from reset release: D, IF, D, IF, four cycles apart.
    Reset = 1'b1;
    ifReq = 1; ifAddr = 32'h10; dReq = 1; dWrite = 0; dAddr = 32'h20;
    applyStimulus(1);
    Reset = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      applyStimulus(1);
      checkOutput($sformatf("contend_c%0d_both", c), {31'd0, ifReady & dReady}, 32'd0);
      if (c % 4 == 1)
        checkOutput($sformatf("contend_c%0d_memaddr", c), memAddr,
                    (((c - 1) / 4) % 2 == 0) ? 32'h20 : 32'h10);
      if (c % 4 == 3) begin
        checkOutput($sformatf("contend_c%0d_dready", c), {31'd0, dReady},
                    (((c - 1) / 4) % 2 == 0) ? 32'd1 : 32'd0);
        checkOutput($sformatf("contend_c%0d_ifready", c), {31'd0, ifReady},
                    (((c - 1) / 4) % 2 == 0) ? 32'd0 : 32'd1);
      end else begin
        checkOutput($sformatf("contend_c%0d_ready", c), {30'd0, ifReady, dReady}, 32'd0);
      end
    end
    ifReq = 0; dReq = 0;
    applyStimulus(1);
    checkOutput("contend_dreaddata", dReadData, 32'hAAAA5555);
    checkOutput("contend_ifdata", ifData, 32'h12345678);

    // Reset arriving during the first busy cycle of a store.
    dReq = 1; dWrite = 1; dAddr = 32'h44; dWriteData = 32'h11111111;
    applyStimulus(1);
    checkOutput("rststore_e0_memwrite", {31'd0, memWrite}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    checkOutput("rststore_memwrite", {31'd0, memWrite}, 32'd0);
    checkOutput("rststore_busy", {31'd0, busy}, 32'd0);
    checkOutput("rststore_memaddr", memAddr, 32'd0);
    checkOutput("rststore_dready", {31'd0, dReady}, 32'd0);
    dReq = 0; dWrite = 0;
    applyStimulus(1);
    Reset = 1'b0;
    seenReady = 1'b0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1);
      if (dReady) seenReady = 1'b1;
    end
    checkOutput("rststore_no_dready", {31'd0, seenReady}, 32'd0);

    // Back-to-back fetches at MEM_LATENCY=1: one-cycle reads, pulses 3 cycles apart.
    fReq = 1; fAddr = 32'h0C;
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(1);
      checkOutput($sformatf("lat1_c%0d_memread", c), {31'd0, fMemRead},
                  ((c - 1) % 3 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("lat1_c%0d_ifready", c), {31'd0, fIfReady},
                  ((c - 1) % 3 == 1) ? 32'd1 : 32'd0);
      if ((c - 1) % 3 == 1)
        checkOutput($sformatf("lat1_c%0d_ifdata", c), fIfData, 32'hCAFEF00D);
    end
    fReq = 0;
    applyStimulus(2);
    checkOutput("lat1_memwrite", {31'd0, fMemWrite}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
